truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper.sv | 78 +++++++
 tb/tb_truth_table_sweeper.sv | 110 +++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input vector of a combinational DUT in turn and
// compares its output against a golden truth table latched when the sweep starts.
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   start          request a full sweep (accepted only when not busy)
//   expected       golden truth table, bit i = expected output for vector i
//   dut_out        DUT output under test
//   vec            vector driven to the DUT, MSB first
//   busy / done    sweep in progress / results valid
//   sample_valid   one-cycle strobe on the cycle dut_out is compared
//   mismatch_count number of failing vectors
//   fail_mask      bit i set when vector i failed
module truth_table_sweeper #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   expected,
  input  logic                 dut_out,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic                 sample_valid,
  output logic [N_IN:0]        mismatch_count,
  output logic [2**N_IN-1:0]   fail_mask
);
  localparam int NV = 2**N_IN;
  localparam int CW = $clog2(SETTLE + 1);
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [NV-1:0] exp_q;
  logic accept, last, miss;
  // The counter runs SETTLE..0 per vector; the zero cycle is the sample cycle,
  // giving SETTLE+1 cycles on every vector.
  always_comb begin
    busy = state == ST_SETTLE;
    done = state == ST_DONE;
    sample_valid = busy && cnt == '0;
    accept = !busy && start;
    last = vec == '1;
    miss = sample_valid && (dut_out != exp_q[vec]);
    state_n = accept ? ST_SETTLE : (sample_valid && last) ? ST_DONE : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ST_IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec <= '0;
      cnt <= '0;
      exp_q <= '0;
      mismatch_count <= '0;
      fail_mask <= '0;
    end else if (accept) begin
      vec <= '0;
      cnt <= CW'(SETTLE);
      exp_q <= expected;
      mismatch_count <= '0;
      fail_mask <= '0;
    end else if (busy) begin
      if (!sample_valid) cnt <= cnt - CW'(1);
      else begin
        if (miss) begin
          mismatch_count <= mismatch_count + (N_IN+1)'(1);
          fail_mask[vec] <= 1'b1;
        end
        // The last vector is held on vec once DONE is entered.
        if (!last) begin
          vec <= vec + N_IN'(1);
          cnt <= CW'(SETTLE);
        end
      end
    end
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: table-driven sweeps with a result scoreboard plus reset/restart sequences.
module tb_truth_table_sweeper;
  logic clk = 0, reset = 1, start = 0, dut_out;
  logic [3:0] expected = 4'b1000;
  logic [1:0] vec;
  logic busy, done, sample_valid;
  logic [2:0] mismatch_count;
  logic [3:0] fail_mask;
  int mode = 0;
  int checks = 0, errors = 0;
  typedef struct {logic [2:0] cnt; logic [3:0] mask;} res_t;
  typedef struct {int mode; logic [3:0] exp; bit mid; logic [2:0] cnt; logic [3:0] mask;} vec_t;
  res_t q[$];
  vec_t tbl[5];

  truth_table_sweeper #(.N_IN(2), .SETTLE(4)) dut (
    .clk(clk), .reset(reset), .start(start), .expected(expected), .dut_out(dut_out),
    .vec(vec), .busy(busy), .done(done), .sample_valid(sample_valid),
    .mismatch_count(mismatch_count), .fail_mask(fail_mask));

  always #5 clk = ~clk;
  // mode 0: good AND, 1: stuck-at-0, 2: inverted AND
  always_comb dut_out = mode == 0 ? (vec[1] & vec[0]) : mode == 1 ? 1'b0 : ~(vec[1] & vec[0]);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vec"}, vec, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sv"}, sample_valid, 0);
    chk({tag, "_cnt"}, mismatch_count, 0);
    chk({tag, "_mask"}, fail_mask, 0);
  endtask

  // Pulses start, follows the sweep cycle by cycle, optionally aborts with reset at cycle abort_at.
  task automatic sweep(input int m, input logic [3:0] e, input bit mid, input res_t r, input int abort_at);
    @(negedge clk);
    mode = m;
    expected = e;
    start = 1;
    q.push_back(r);
    @(posedge clk);
    #1 start = 0;
    chk("start_clr_cnt", mismatch_count, 0);
    chk("start_clr_mask", fail_mask, 0);
    for (int c = 0; c < 20; c++) begin
      chk("busy", busy, 1);
      chk("done_low", done, 0);
      chk("vec_seq", vec, c / 5);
      chk("sample_valid", sample_valid, (c % 5) == 4);
      if (c == abort_at) begin
        reset = 1;
        #1 chk_zero("async_rst");
        q.delete();
        @(negedge clk) reset = 0;
        repeat (3) @(posedge clk);
        #1 chk_zero("idle_hold");
        return;
      end
      if (mid && c == 10) begin start = 1; expected = 4'b0000; end
      if (mid && c == 11) begin start = 0; expected = e; end
      @(posedge clk);
      #1;
    end
    chk("done_at_20", done, 1);
    chk("busy_low", busy, 0);
    chk("vec_hold", vec, 3);
    if (q.size() == 0) chk("scoreboard_empty", 1, 0);
    else begin
      res_t x = q.pop_front();
      chk("mismatch_count", mismatch_count, x.cnt);
      chk("fail_mask", fail_mask, x.mask);
    end
    repeat (2) @(posedge clk);
    #1 chk("done_hold", done, 1);
  endtask

  initial begin
    tbl[0] = '{0, 4'b1000, 0, 3'd0, 4'b0000};
    tbl[1] = '{1, 4'b1000, 0, 3'd1, 4'b1000};
    tbl[2] = '{0, 4'b1000, 0, 3'd0, 4'b0000};
    tbl[3] = '{2, 4'b1000, 0, 3'd4, 4'b1111};
    tbl[4] = '{0, 4'b0110, 0, 3'd3, 4'b1110};
    #2 chk_zero("reset");
    @(negedge clk) reset = 0;
    repeat (3) @(posedge clk);
    #1 chk_zero("post_reset_idle");
    // tbl[2] follows the stuck-at-0 run: restart from DONE must clear results
    for (int i = 0; i < 5; i++) sweep(tbl[i].mode, tbl[i].exp, tbl[i].mid, '{tbl[i].cnt, tbl[i].mask}, -1);
    sweep(0, 4'b1000, 1, '{3'd0, 4'b0000}, -1);
    sweep(2, 4'b1000, 0, '{3'd4, 4'b1111}, 9);
    sweep(0, 4'b1000, 0, '{3'd0, 4'b0000}, -1);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
